// File: rtl/vscale_hpm_counter_bank.sv
// vscale_hpm_counter_bank
//   Bank of NUM_COUNTERS hardware performance-monitor counters on the CSR
//   command bus. Each counter is COUNTER_WIDTH bits, split into a low half at
//   BASE_ADDR+i and a high half at BASEH_ADDR+i. Also holds per-channel
//   inhibit, sticky overflow flags, overflow interrupt enables, and an
//   optional snapshot that makes a low-then-high read of a counter coherent.
//
// Ports
//   clk_i        clock, rising edge
//   reset_i      synchronous active-high reset
//   addr_i       CSR address
//   cmd_i        CSR command: 0 idle, 4 read, 5 write, 6 set, 7 clear
//   wdata_i      CSR write operand
//   rdata_o      combinational read data, 0 when unmapped
//   defined_o    combinational, 1 when addr_i maps into this block
//   event_inc_i  per-channel increment strobe
//   irq_o        |(ovf & ovf_en)

// Single counter channel. A CSR write to either half takes priority over the
// increment in the same cycle; the increment is dropped and no wrap is flagged.
module vscale_hpm_counter #(
  parameter int CW  = 64,
  parameter int XPR = 32
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           inc_i,
  input  logic           wr_lo_i,
  input  logic           wr_hi_i,
  input  logic [XPR-1:0] wv_i,
  output logic [CW-1:0]  cnt_o,
  output logic           wrap_o
);
  localparam int HW = CW - XPR;

  logic [CW-1:0] cnt_q, cnt_d;

  assign cnt_o  = cnt_q;
  assign wrap_o = inc_i & ~wr_lo_i & ~wr_hi_i & (&cnt_q);

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i)      cnt_d[XPR-1:0]  = wv_i;
    else if (wr_hi_i) cnt_d[CW-1:XPR] = wv_i[HW-1:0];
    else if (inc_i)   cnt_d           = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

module vscale_hpm_counter_bank #(
  parameter int          NUM_COUNTERS  = 4,
  parameter int          COUNTER_WIDTH = 64,
  parameter int          XPR_LEN       = 32,
  parameter logic [11:0] BASE_ADDR     = 12'hC03,
  parameter logic [11:0] BASEH_ADDR    = 12'hC83,
  parameter logic [11:0] INHIBIT_ADDR  = 12'h7C0,
  parameter logic [11:0] OVF_ADDR      = 12'h7C1,
  parameter logic [11:0] OVF_EN_ADDR   = 12'h7C2,
  parameter bit          SNAPSHOT      = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [11:0]             addr_i,
  input  logic [2:0]              cmd_i,
  input  logic [XPR_LEN-1:0]      wdata_i,
  output logic [XPR_LEN-1:0]      rdata_o,
  output logic                    defined_o,
  input  logic [NUM_COUNTERS-1:0] event_inc_i,
  output logic                    irq_o
);
  localparam int N     = NUM_COUNTERS;
  localparam int CW    = COUNTER_WIDTH;
  localparam int XPR   = XPR_LEN;
  localparam int HW    = CW - XPR;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef struct packed {
    logic [11:0]    addr;
    logic [2:0]     cmd;
    logic [XPR-1:0] wdata;
  } csr_req_t;

  csr_req_t req;
  assign req = '{addr: addr_i, cmd: cmd_i, wdata: wdata_i};

  // ---------------- address decode ----------------
  logic [N-1:0] lo_sel, hi_sel;
  logic         inh_sel, ovf_sel, oen_sel;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      lo_sel[i] = (req.addr == BASE_ADDR  + 12'(i));
      hi_sel[i] = (req.addr == BASEH_ADDR + 12'(i));
    end
  end

  assign inh_sel   = (req.addr == INHIBIT_ADDR);
  assign ovf_sel   = (req.addr == OVF_ADDR);
  assign oen_sel   = (req.addr == OVF_EN_ADDR);
  assign defined_o = (|lo_sel) | (|hi_sel) | inh_sel | ovf_sel | oen_sel;

  logic acc, wr;
  assign acc = req.cmd[2] & defined_o;
  assign wr  = acc & (req.cmd[1] | req.cmd[0]);

  // ---------------- state ----------------
  logic [N-1:0][CW-1:0] cnt;
  logic [N-1:0]         wrap;
  logic [N-1:0]         inhibit_q, inhibit_d;
  logic [N-1:0]         ovf_q, ovf_d;
  logic [N-1:0]         oen_q, oen_d;

  // Snapshot view: snap_hit means this high-half address is served from
  // the shadow rather than the live counter.
  logic          snap_hit;
  logic [HW-1:0] shadow_rd;

  // ---------------- read mux ----------------
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < N; i++) begin
      if (lo_sel[i]) rdata_o = cnt[i][XPR-1:0];
      if (hi_sel[i]) rdata_o = snap_hit ? XPR'(shadow_rd) : XPR'(cnt[i][CW-1:XPR]);
    end
    if (inh_sel) rdata_o = XPR'(inhibit_q);
    if (ovf_sel) rdata_o = XPR'(ovf_q);
    if (oen_sel) rdata_o = XPR'(oen_q);
  end

  // Effective write value; set/clear act on what this cycle reads back,
  // which for a snapshotted high half is the shadow.
  logic [XPR-1:0] wv;
  always_comb begin
    unique case (req.cmd[1:0])
      2'b10:   wv = rdata_o | req.wdata;
      2'b11:   wv = rdata_o & ~req.wdata;
      default: wv = req.wdata;
    endcase
  end

  // ---------------- counters ----------------
  for (genvar g = 0; g < N; g++) begin : g_ch
    vscale_hpm_counter #(.CW(CW), .XPR(XPR)) u_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (event_inc_i[g] & ~inhibit_q[g]),
      .wr_lo_i (wr & lo_sel[g]),
      .wr_hi_i (wr & hi_sel[g]),
      .wv_i    (wv),
      .cnt_o   (cnt[g]),
      .wrap_o  (wrap[g])
    );
  end

  // ---------------- control registers ----------------
  always_comb begin
    inhibit_d = inhibit_q;
    oen_d     = oen_q;
    ovf_d     = ovf_q;
    if (wr & inh_sel) inhibit_d = wv[N-1:0];
    if (wr & oen_sel) oen_d     = wv[N-1:0];
    if (wr & ovf_sel) ovf_d     = wv[N-1:0];
    // hardware overflow wins over a same-cycle software write
    ovf_d = ovf_d | wrap;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      inhibit_q <= '0;
      ovf_q     <= '0;
      oen_q     <= '0;
    end else begin
      inhibit_q <= inhibit_d;
      ovf_q     <= ovf_d;
      oen_q     <= oen_d;
    end
  end

  assign irq_o = |(ovf_q & oen_q);

  // ---------------- snapshot ----------------
  if (SNAPSHOT) begin : g_snap
    logic [HW-1:0]    shadow_q, shadow_d;
    logic             snap_valid_q, snap_valid_d;
    logic [IDX_W-1:0] snap_idx_q, snap_idx_d;

    always_comb begin
      snap_hit = 1'b0;
      for (int i = 0; i < N; i++)
        if (hi_sel[i] && snap_valid_q && snap_idx_q == IDX_W'(i)) snap_hit = 1'b1;
    end

    always_comb begin
      shadow_d     = shadow_q;
      snap_valid_d = snap_valid_q;
      snap_idx_d   = snap_idx_q;
      if (req.cmd[2]) begin
        // low-half access captures the upper bits as they are before this edge
        for (int i = 0; i < N; i++) begin
          if (lo_sel[i]) begin
            shadow_d     = cnt[i][CW-1:XPR];
            snap_valid_d = 1'b1;
            snap_idx_d   = IDX_W'(i);
          end
        end
        // consuming the shadow (read or write) retires it
        if (snap_hit) snap_valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        shadow_q     <= '0;
        snap_valid_q <= 1'b0;
        snap_idx_q   <= '0;
      end else begin
        shadow_q     <= shadow_d;
        snap_valid_q <= snap_valid_d;
        snap_idx_q   <= snap_idx_d;
      end
    end

    assign shadow_rd = shadow_q;
  end else begin : g_nosnap
    assign snap_hit  = 1'b0;
    assign shadow_rd = '0;
  end

endmodule
